// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin codes and coin-value decode for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_INV  = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;
    localparam logic [1:0] COIN_TWO  = 2'b11;

    function automatic logic [1:0] coin_val(input logic [1:0] coin);
        return (coin == COIN_NONE || coin == COIN_INV) ? 2'd0 : coin == COIN_ONE ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// vend_dispense_ctrl_if: coin acceptor, dispenser and change-hopper signals of the vending controller.
interface vend_dispense_ctrl_if #(parameter int CW = 3);

    logic [1:0]    coin;
    logic          cancel;
    logic          disp_req;
    logic          disp_ack;
    logic          chg_req;
    logic          chg_ack;
    logic          prod;
    logic          coin_reject;
    logic [CW-1:0] credit;
    logic          busy;

    modport master (
        input  coin, cancel, disp_ack, chg_ack,
        output disp_req, chg_req, prod, coin_reject, credit, busy
    );

    modport slave (
        output coin, cancel, disp_ack, chg_ack,
        input  disp_req, chg_req, prod, coin_reject, credit, busy
    );

endinterface

// File: rtl/vend_timeout_timer.sv
// vend_timeout_timer: inactivity counter that pulses expire on its TIMEOUT-th enabled cycle.
module vend_timeout_timer #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TW-1:0] cnt;

    assign expire = en && cnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (clr || expire) ? '0 : en ? cnt + 1'b1 : cnt;
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: coin credit, product dispense handshake and one-coin-at-a-time change/refund sequencer.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE   = 3,
    parameter int CW      = 3,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input logic                  clk,
    input logic                  rst,
    vend_dispense_ctrl_if.master bus
);

    state_t        state, state_n;
    logic [CW-1:0] credit_n;
    logic [CW-1:0] sum;
    logic [1:0]    val;
    logic          tmr_en;
    logic          expire;

    assign val    = coin_val(bus.coin);
    assign sum    = bus.credit + CW'(val);
    // Only a coinless, cancel-free COLLECT cycle counts as inactivity.
    assign tmr_en = state == COLLECT && val == 2'd0 && !bus.cancel;

    vend_timeout_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!tmr_en),
        .en     (tmr_en),
        .expire (expire)
    );

    always_comb begin
        state_n  = state;
        credit_n = bus.credit;
        case (state)
            IDLE: begin
                if (val != 2'd0) begin
                    state_n  = COLLECT;
                    credit_n = CW'(val);
                end
            end
            COLLECT: begin
                if (sum >= CW'(PRICE)) begin
                    state_n  = DISPENSE;
                    credit_n = sum - CW'(PRICE);
                end else if (bus.cancel) begin
                    state_n  = CHANGE;
                    credit_n = sum;
                end else if (val != 2'd0)
                    credit_n = sum;
                else if (expire)
                    state_n = CHANGE;
            end
            DISPENSE: begin
                if (bus.disp_ack)
                    state_n = bus.credit != '0 ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (bus.chg_ack) begin
                    credit_n = bus.credit - 1'b1;
                    state_n  = bus.credit == CW'(1) ? IDLE : CHANGE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.credit      <= '0;
            bus.disp_req    <= 1'b0;
            bus.chg_req     <= 1'b0;
            bus.prod        <= 1'b0;
            bus.coin_reject <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_n;
            bus.credit      <= credit_n;
            bus.disp_req    <= state_n == DISPENSE;
            bus.chg_req     <= state_n == CHANGE && credit_n != '0;
            bus.prod        <= state == DISPENSE && bus.disp_ack;
            bus.coin_reject <= (state == DISPENSE || state == CHANGE) && val != 2'd0;
            bus.busy        <= state_n == DISPENSE || state_n == CHANGE;
        end
    end

endmodule
